// File: rtl/dm_port_sched.sv
// dm_port_sched: arbitrates the single data-memory port between LSU load reads
// and an in-order buffer of committed stores. Loads see a fixed 1-cycle read latency.
module dm_port_sched #(
    parameter int WB_DEPTH   = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    // Handshakes: a transfer happens in any cycle where valid and ready are both 1;
    // the requester holds valid and payload stable until that cycle.
    input  logic                      st_in_valid,
    output logic                      st_in_ready,
    input  logic [31:0]               st_in_addr,
    input  logic [31:0]               st_in_data,
    input  logic [31:0]               st_in_wmask,
    input  logic                      ld_req_valid,
    output logic                      ld_req_ready,
    input  logic [31:0]               ld_req_addr,
    input  logic [1:0]                ld_req_tag,
    output logic                      ld_rsp_valid,
    output logic [1:0]                ld_rsp_tag,
    output logic [31:0]               ld_rsp_data,
    input  logic                      drain_req,
    output logic                      wb_empty,
    output logic [$clog2(WB_DEPTH):0] wb_count,
    input  logic [31:0]               DM_rd_data,
    output logic                      DM_c_en,
    output logic                      DM_r_en,
    output logic [31:0]               DM_w_en,
    output logic [31:0]               DM_addr,
    output logic [31:0]               DM_w_data
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SV_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_LOAD  = 2'd1,
        GNT_STORE = 2'd2
    } grant_t;

    logic [31:0]      r_wb_addr [WB_DEPTH];
    logic [31:0]      r_wb_data [WB_DEPTH];
    logic [31:0]      r_wb_mask [WB_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_wb_empty;
    logic [SV_W-1:0]  r_starve;
    logic             r_rsp_valid;
    logic [1:0]       r_rsp_tag;

    logic             w_full;
    logic             w_nonempty;
    logic             w_push;
    logic             w_pop;
    logic             w_hit;
    logic             w_conflict;
    logic             w_force;
    logic [CNT_W-1:0] w_count_next;
    grant_t           w_grant;

    assign w_full     = (r_count == CNT_W'(WB_DEPTH));
    assign w_nonempty = (r_count != '0);
    assign w_push     = st_in_valid && !w_full;
    assign w_pop      = (w_grant == GNT_STORE);

    // Word-granular match against every live entry plus the store entering this cycle.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if ((CNT_W'(i) < r_count) &&
                (r_wb_addr[r_head + PTR_W'(i)][31:2] == ld_req_addr[31:2]))
                w_hit = 1'b1;
        end
        if (w_push && (st_in_addr[31:2] == ld_req_addr[31:2]))
            w_hit = 1'b1;
    end

    assign w_conflict = ld_req_valid && w_hit;
    assign w_force    = w_nonempty && ((r_starve == SV_W'(STARVE_MAX)) || w_full ||
                                       drain_req || w_conflict);

    // A conflicting load is never granted, even when its older store is still entering the buffer.
    always_comb begin
        w_grant = GNT_IDLE;
        if (rst)
            w_grant = GNT_IDLE;
        else if (w_force || (w_nonempty && !ld_req_valid))
            w_grant = GNT_STORE;
        else if (ld_req_valid && !w_conflict)
            w_grant = GNT_LOAD;
    end

    always_comb begin
        ld_req_ready = 1'b0;
        DM_c_en      = 1'b1;
        DM_r_en      = 1'b0;
        DM_w_en      = '1;
        DM_addr      = '0;
        DM_w_data    = '0;
        case (w_grant)
            GNT_LOAD: begin
                ld_req_ready = 1'b1;
                DM_c_en      = 1'b0;
                DM_r_en      = 1'b1;
                DM_addr      = ld_req_addr;
            end
            GNT_STORE: begin
                DM_c_en   = 1'b0;
                DM_addr   = r_wb_addr[r_head];
                DM_w_data = r_wb_data[r_head];
                DM_w_en   = ~r_wb_mask[r_head];
            end
            default: ;
        endcase
    end

    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_wb_empty  <= 1'b1;
            r_starve    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_tag   <= '0;
            for (int i = 0; i < WB_DEPTH; i++) begin
                r_wb_addr[i] <= '0;
                r_wb_data[i] <= '0;
                r_wb_mask[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_wb_addr[r_tail] <= st_in_addr;
                r_wb_data[r_tail] <= st_in_data;
                r_wb_mask[r_tail] <= st_in_wmask;
                r_tail            <= r_tail + PTR_W'(1);
            end
            if (w_pop)
                r_head <= r_head + PTR_W'(1);
            r_count    <= w_count_next;
            r_wb_empty <= (w_count_next == '0);
            if (w_pop || !w_nonempty)
                r_starve <= '0;
            else if (r_starve != SV_W'(STARVE_MAX))
                r_starve <= r_starve + SV_W'(1);
            r_rsp_valid <= (w_grant == GNT_LOAD);
            if (w_grant == GNT_LOAD)
                r_rsp_tag <= ld_req_tag;
        end
    end

    assign st_in_ready  = !w_full;
    assign wb_empty     = r_wb_empty;
    assign wb_count     = r_count;
    assign ld_rsp_valid = r_rsp_valid;
    assign ld_rsp_tag   = r_rsp_tag;
    assign ld_rsp_data  = r_rsp_valid ? DM_rd_data : '0;

endmodule

// File: doc/dm_port_sched.md
Name: dm_port_sched

Overview:
- Schedules the single data-memory port between out-of-order load reads from the LSU and committed stores.
- Committed stores enter a small in-order write buffer and drain to DM when the port is free, or when forced by starvation, buffer-full, fence or address conflict.
- Sits between the LSU (load requests, store commit) and the DM macro. One DM operation per cycle; loads get a fixed 1-cycle read latency.

Parameters:
- WB_DEPTH, 4: write-buffer entries; power of 2, at least 2.
- STARVE_MAX, 3: cycles a non-empty buffer may be denied before a store is forced.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- st_in_valid  in  1  committed store presented
- st_in_ready  out  1  buffer can accept store
- st_in_addr  in  32  store byte address
- st_in_data  in  32  store data, already lane-aligned
- st_in_wmask  in  32  bit mask, 1 = write bit
- ld_req_valid  in  1  load read requested
- ld_req_ready  out  1  load granted this cycle
- ld_req_addr  in  32  load byte address
- ld_req_tag  in  2  LQ index of requesting load
- ld_rsp_valid  out  1  load data valid
- ld_rsp_tag  out  2  LQ index of returned data
- ld_rsp_data  out  32  DM read word
- drain_req  in  1  fence; force store drain
- wb_empty  out  1  buffer empty
- wb_count  out  $clog2(WB_DEPTH)+1  occupancy
- DM_rd_data  in  32  DM read data, valid the cycle after a read
- DM_c_en  out  1  chip enable, active-low
- DM_r_en  out  1  1 = read, 0 = write
- DM_w_en  out  32  bit write enable, active-low
- DM_addr  out  32  DM address
- DM_w_data  out  32  DM write data

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - Clears the buffer, head/tail pointers and starve counter.
  - Outputs: ld_rsp_valid=0, ld_rsp_tag=0, ld_rsp_data=0, wb_empty=1, wb_count=0, st_in_ready=1, DM_c_en=1, DM_r_en=0, DM_w_en=all 1s, DM_addr=0, DM_w_data=0.
  - Reset during a granted load drops its response.
- Write buffer: circular FIFO, WB_DEPTH entries of {addr, data, wmask}.
  - st_in_ready = !full. Push on st_in_valid & st_in_ready.
  - A full buffer rejects a push even when a pop occurs the same cycle.
  - Pointers wrap modulo WB_DEPTH. wb_count is registered.
- conflict = ld_req_valid and ld_req_addr[31:2] equals addr[31:2] of any valid entry, or of st_in when a push occurs this cycle.
- force_st = buffer non-empty AND (starve == STARVE_MAX OR full OR drain_req OR conflict).
- Grant per cycle, combinational:
  - STORE if force_st, or if the buffer is non-empty and ld_req_valid=0.
  - Else LOAD if ld_req_valid.
  - Else IDLE.
- LOAD:
  - ld_req_ready=1, DM_c_en=0, DM_r_en=1, DM_addr=ld_req_addr, DM_w_en=all 1s.
  - Next cycle: ld_rsp_valid=1, ld_rsp_tag = tag registered at grant, ld_rsp_data=DM_rd_data. Exactly 1-cycle latency.
- STORE:
  - ld_req_ready=0, DM_c_en=0, DM_r_en=0, DM_addr=head.addr, DM_w_data=head.data, DM_w_en = ~head.wmask.
  - Head pops at the clock edge.
- IDLE: DM_c_en=1, DM_r_en=0, DM_w_en=all 1s, DM_addr=0, DM_w_data=0.
- ld_rsp_valid=0 in any cycle not following a LOAD grant. Responses are back-to-back capable.
- Starve counter: resets to 0 on a STORE grant or when the buffer is empty. Otherwise increments, saturating at STARVE_MAX.
- A load is never granted while an older buffered store to the same word exists. Loads never observe stale data.
- A pushed entry is eligible for STORE from the next cycle. The same-cycle push is covered only by the conflict check.
- The requester keeps ld_req_valid, addr and tag stable until ld_req_ready.
- drain_req held: stores win every cycle until wb_empty=1, then loads resume.

Test Plan:
- Load only, empty buffer: ld_req addr=0x100, tag=2, DM_rd_data=0xDEADBEEF next cycle -> ld_req_ready=1 in cycle 0, DM_r_en=1, DM_addr=0x100; cycle 1 ld_rsp_valid=1, tag=2, data=0xDEADBEEF.
- Store only: push addr=0x200, data=0x12345678, wmask=0x0000FFFF -> next cycle DM_r_en=0, DM_addr=0x200, DM_w_en=0xFFFF0000, DM_w_data=0x12345678, DM_c_en=0; following cycle wb_empty=1.
- Conflict: buffer holds store to 0x300, load to 0x302 requested -> store granted first, load granted next cycle; load to 0x304 under the same conditions -> granted immediately.
- Starvation: STARVE_MAX=3, one store buffered, continuous loads to non-conflicting addresses -> 3 load grants, store forced in cycle 4, then loads resume.
- Full/wrap: push 4 stores with loads continuously asserted -> st_in_ready=0 at count 4, 5th push rejected, full forces a store; push 6 stores total over time -> DM write addresses in push order across pointer wrap.
- Fence and reset: drain_req=1 with 3 entries -> 3 consecutive STOREs, wb_empty=1 after cycle 3; assert rst in the cycle after a load grant -> ld_rsp_valid=0, wb_count=0, DM_c_en=1.
